count_checker: RTL

Receive-side monitor for a free-running binary counter stream. It samples a W-bit count value on every valid cycle and locks onto the sequence. Once locked, it checks that each sample equals the previous one plus one, modulo 2^WIDTH. It reports mismatches, wrap-arounds and the first failing pair, and sits at the consuming end of any counter output (for example, a bench or an on-chip self-check of counter blocks).

---
 rtl/count_checker.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/count_checker.sv
// ---------------------------------------------------------------------------
// count_checker
//
// Receive-side monitor for a free-running binary counter stream. It seeds on
// one valid sample, and locks after LOCK_N consecutive +1 increments (modulo
// 2^WIDTH). Once locked, a mismatching sample is reported as an error and the
// checker drops back to search for a fresh seed.
//
// Parameters:
//   WIDTH   bit width of the checked count
//   LOCK_N  consecutive correct increments required for lock (>= 1)
//   ERR_W   width of the saturating error and wrap counters
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    in_count carries a sample this cycle
//   in_count    observed count value
//   clear       synchronous clear, same effect as reset
//   locked      checker is locked to the sequence
//   err_pulse   one-cycle pulse per mismatch detected while locked
//   err_sticky  set by any error, cleared only by rst_n / clear
//   err_cnt     saturating mismatch count
//   wrap_cnt    saturating count of matched all-ones -> 0 steps while locked
//   first_exp   expected value at the first error since clear
//   first_got   received value at the first error since clear
// ---------------------------------------------------------------------------
module count_checker #(
   parameter int WIDTH  = 8,
   parameter int LOCK_N = 4,
   parameter int ERR_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_count,
   input  logic             clear,
   output logic             locked,
   output logic             err_pulse,
   output logic             err_sticky,
   output logic [ERR_W-1:0] err_cnt,
   output logic [ERR_W-1:0] wrap_cnt,
   output logic [WIDTH-1:0] first_exp,
   output logic [WIDTH-1:0] first_got
);

   localparam int CNT_W = (LOCK_N > 1) ? $clog2(LOCK_N) : 1;
   localparam logic [CNT_W-1:0] MATCH_LAST = CNT_W'(LOCK_N - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] exp_val, exp_n;
   logic [CNT_W-1:0] match_cnt, match_n;
   logic             is_match;
   logic             locked_n;
   logic             pulse_n;
   logic             sticky_n;
   logic [ERR_W-1:0] err_cnt_n;
   logic [ERR_W-1:0] wrap_n;
   logic [WIDTH-1:0] first_exp_n;
   logic [WIDTH-1:0] first_got_n;

   // State and every output are registered here; all decisions live in the
   // combinational block below.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= SEARCH;
         exp_val    <= '0;
         match_cnt  <= '0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         err_sticky <= 1'b0;
         err_cnt    <= '0;
         wrap_cnt   <= '0;
         first_exp  <= '0;
         first_got  <= '0;
      end else begin
         state      <= state_n;
         exp_val    <= exp_n;
         match_cnt  <= match_n;
         locked     <= locked_n;
         err_pulse  <= pulse_n;
         err_sticky <= sticky_n;
         err_cnt    <= err_cnt_n;
         wrap_cnt   <= wrap_n;
         first_exp  <= first_exp_n;
         first_got  <= first_got_n;
      end
   end

   // Next-state logic. clear overrides sample processing, so a mismatch on
   // the same cycle as clear leaves no trace.
   always_comb begin
      state_n     = state;
      exp_n       = exp_val;
      match_n     = match_cnt;
      pulse_n     = 1'b0;
      sticky_n    = err_sticky;
      err_cnt_n   = err_cnt;
      wrap_n      = wrap_cnt;
      first_exp_n = first_exp;
      first_got_n = first_got;
      is_match    = (in_count == exp_val);

      if (clear) begin
         state_n     = SEARCH;
         exp_n       = '0;
         match_n     = '0;
         sticky_n    = 1'b0;
         err_cnt_n   = '0;
         wrap_n      = '0;
         first_exp_n = '0;
         first_got_n = '0;
      end else if (in_valid) begin
         case (state)
            SEARCH: begin
               exp_n   = in_count + 1'b1;
               match_n = '0;
               state_n = VERIFY;
            end
            VERIFY: begin
               if (is_match) begin
                  exp_n = exp_val + 1'b1;
                  if (match_cnt == MATCH_LAST) begin
                     state_n = LOCKED;
                  end else begin
                     match_n = match_cnt + 1'b1;
                  end
               end else begin
                  // Pre-lock mismatches silently reseed from this sample.
                  exp_n   = in_count + 1'b1;
                  match_n = '0;
               end
            end
            LOCKED: begin
               if (is_match) begin
                  exp_n = exp_val + 1'b1;
                  if ((in_count == '0) && (wrap_cnt != '1)) begin
                     wrap_n = wrap_cnt + 1'b1;
                  end
               end else begin
                  pulse_n  = 1'b1;
                  sticky_n = 1'b1;
                  if (err_cnt != '1) begin
                     err_cnt_n = err_cnt + 1'b1;
                  end
                  if (!err_sticky) begin
                     first_exp_n = exp_val;
                     first_got_n = in_count;
                  end
                  // The bad sample is discarded; the next one seeds.
                  state_n = SEARCH;
               end
            end
            default: begin
               state_n = SEARCH;
            end
         endcase
      end

      locked_n = (state_n == LOCKED);
   end

endmodule
